// File: rtl/lcd_dma_pkg.sv
// Shared types and AXI4 encodings for the LCD DMA burst-read responder.
package lcd_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/lcd_dma_axi_reader.sv
// Turns one LCD DMA burst request into a single AXI4 INCR read burst and
// streams the returned words back as one-cycle valid pulses.
module lcd_dma_axi_reader
  import lcd_dma_pkg::*;
#(
  parameter int         BURST_SIZE  = 8,
  parameter logic [3:0] ARCACHE_VAL = 4'b0011
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [28:0] DMA_RD_ADDR,
  input  logic        DMA_START,
  output logic        DMA_READY,
  output logic [31:0] DMA_RD_DATA,
  output logic        DMA_RD_DATA_VALID,
  input  logic        ERR_CLEAR,
  output logic        RESP_ERR,
  output logic        LAST_ERR,
  output logic [31:0] M_AXI_ARADDR,
  output logic [7:0]  M_AXI_ARLEN,
  output logic [2:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  output logic [3:0]  M_AXI_ARCACHE,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam int              CNT_W     = $clog2(BURST_SIZE) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_SIZE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             r_hs;
  logic             at_last;
  logic             data_beat;
  logic             resp_err_set;
  logic             last_err_set;

  assign M_AXI_ARLEN   = 8'(BURST_SIZE - 1);
  assign M_AXI_ARSIZE  = AXI_SIZE_4B;
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARCACHE = ARCACHE_VAL;
  assign M_AXI_ARPROT  = 3'b000;

  // RREADY is a registered output, so a handshake can only occur in DATA or DRAIN.
  assign r_hs         = M_AXI_RVALID & M_AXI_RREADY;
  assign at_last      = (beat_cnt_q == LAST_BEAT);
  assign data_beat    = r_hs && (state_q == DATA);
  assign resp_err_set = data_beat && (M_AXI_RRESP inside {2'b10, 2'b11});
  assign last_err_set = data_beat && (M_AXI_RLAST != at_last);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (DMA_START) state_d = ADDR;
      ADDR:  if (M_AXI_ARREADY) state_d = DATA;
      DATA: begin
        if (r_hs) begin
          if (M_AXI_RLAST)  state_d = IDLE;
          else if (at_last) state_d = DRAIN;
        end
      end
      DRAIN: if (r_hs && M_AXI_RLAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q           <= IDLE;
      DMA_READY         <= 1'b1;
      M_AXI_ARVALID     <= 1'b0;
      M_AXI_RREADY      <= 1'b0;
      M_AXI_ARADDR      <= '0;
      beat_cnt_q        <= '0;
      DMA_RD_DATA       <= '0;
      DMA_RD_DATA_VALID <= 1'b0;
      RESP_ERR          <= 1'b0;
      LAST_ERR          <= 1'b0;
    end else begin
      state_q       <= state_d;
      DMA_READY     <= (state_d == IDLE);
      M_AXI_ARVALID <= (state_d == ADDR);
      M_AXI_RREADY  <= (state_d == DATA) || (state_d == DRAIN);

      if (state_q == IDLE && DMA_START)
        M_AXI_ARADDR <= {DMA_RD_ADDR, 2'b00};

      if (state_q == ADDR && M_AXI_ARREADY)
        beat_cnt_q <= '0;
      else if (data_beat && !at_last)
        beat_cnt_q <= beat_cnt_q + 1'b1;

      DMA_RD_DATA_VALID <= data_beat;
      if (data_beat)
        DMA_RD_DATA <= M_AXI_RDATA;

      // A new error outranks a simultaneous clear.
      RESP_ERR <= resp_err_set | (RESP_ERR & ~ERR_CLEAR);
      LAST_ERR <= last_err_set | (LAST_ERR & ~ERR_CLEAR);
    end
  end

endmodule

// File: tb/tb_lcd_dma_axi_reader.sv
// Directed bench for lcd_dma_axi_reader: an AXI read-slave driver pushes the
// expected words into a scoreboard queue and a monitor checks each pulse.
module tb_lcd_dma_axi_reader;

  localparam int BURST_SIZE = 8;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic [28:0] DMA_RD_ADDR = '0;
  logic        DMA_START = 1'b0;
  logic        DMA_READY;
  logic [31:0] DMA_RD_DATA;
  logic        DMA_RD_DATA_VALID;
  logic        ERR_CLEAR = 1'b0;
  logic        RESP_ERR;
  logic        LAST_ERR;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic [3:0]  M_AXI_ARCACHE;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY = 1'b0;
  logic [31:0] M_AXI_RDATA = '0;
  logic [1:0]  M_AXI_RRESP = '0;
  logic        M_AXI_RLAST = 1'b0;
  logic        M_AXI_RVALID = 1'b0;
  logic        M_AXI_RREADY;

  lcd_dma_axi_reader #(.BURST_SIZE(BURST_SIZE), .ARCACHE_VAL(4'b0011)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .DMA_RD_ADDR(DMA_RD_ADDR), .DMA_START(DMA_START), .DMA_READY(DMA_READY),
    .DMA_RD_DATA(DMA_RD_DATA), .DMA_RD_DATA_VALID(DMA_RD_DATA_VALID),
    .ERR_CLEAR(ERR_CLEAR), .RESP_ERR(RESP_ERR), .LAST_ERR(LAST_ERR),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pulse_cnt = 0;
  int          ar_cnt = 0;
  int          ar_base = 0;
  logic        prev_arv = 1'b0;
  logic [31:0] prev_ara = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest expected word and cycle.
  always @(negedge CLK) begin
    if (RESETN) begin
      if (DMA_RD_DATA_VALID) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got data %h expected no pulse", DMA_RD_DATA);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rd_data", DMA_RD_DATA, mon_e.data);
          chk("pulse_cycle", 32'(cyc), 32'(mon_e.due));
        end
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) ar_cnt++;
      if (M_AXI_ARVALID && prev_arv) chk("araddr_stable", M_AXI_ARADDR, prev_ara);
      prev_arv = M_AXI_ARVALID;
      prev_ara = M_AXI_ARADDR;
    end else begin
      prev_arv = 1'b0;
    end
  end

  task automatic start(input logic [28:0] addr);
    DMA_RD_ADDR = addr;
    DMA_START   = 1'b1;
    @(posedge CLK); #1;
    DMA_START   = 1'b0;
  endtask

  task automatic addr_phase(input int delay, input logic [31:0] exp_addr);
    int n = 0;
    while (!M_AXI_ARVALID && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("arvalid", 32'(M_AXI_ARVALID), 32'd1);
    repeat (delay) begin
      @(posedge CLK); #1;
      chk("arvalid_hold", 32'(M_AXI_ARVALID), 32'd1);
    end
    M_AXI_ARREADY = 1'b1;
    chk("araddr", M_AXI_ARADDR, exp_addr);
    @(posedge CLK); #1;
    M_AXI_ARREADY = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic last,
                      input bit fwd, input int gap, input logic clr);
    int n = 0;
    repeat (gap) begin
      @(posedge CLK); #1;
    end
    M_AXI_RVALID = 1'b1;
    M_AXI_RDATA  = d;
    M_AXI_RRESP  = resp;
    M_AXI_RLAST  = last;
    ERR_CLEAR    = clr;
    while (!M_AXI_RREADY && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!M_AXI_RREADY) begin
      checks++;
      errors++;
      $display("FAIL rready_timeout: got RREADY=0 expected 1 within 50 cycles");
    end else if (fwd) begin
      exp_q.push_back('{d, cyc + 1});
    end
    @(posedge CLK); #1;
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    M_AXI_RRESP  = 2'b00;
    ERR_CLEAR    = 1'b0;
  endtask

  task automatic burst_beats(input logic [31:0] tag, input int first, input int nbeats,
                             input int last_at, input bit rand_gap);
    for (int i = first; i < first + nbeats; i++)
      beat(tag + 32'(i), 2'b00, i == last_at, (i < BURST_SIZE) && (i <= last_at),
           rand_gap ? int'($urandom_range(0, 2)) : 0, 1'b0);
  endtask

  task automatic end_test(input int n);
    @(posedge CLK); #1;
    chk("pulse_count", 32'(pulse_cnt), 32'(n));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    pulse_cnt = 0;
  endtask

  task automatic clear_errors();
    ERR_CLEAR = 1'b1;
    @(posedge CLK); #1;
    ERR_CLEAR = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"},    32'(DMA_READY), 32'd1);
    chk({tag, "_rd_data"},  DMA_RD_DATA, 32'd0);
    chk({tag, "_rd_valid"}, 32'(DMA_RD_DATA_VALID), 32'd0);
    chk({tag, "_arvalid"},  32'(M_AXI_ARVALID), 32'd0);
    chk({tag, "_araddr"},   M_AXI_ARADDR, 32'd0);
    chk({tag, "_rready"},   32'(M_AXI_RREADY), 32'd0);
    chk({tag, "_resp_err"}, 32'(RESP_ERR), 32'd0);
    chk({tag, "_last_err"}, 32'(LAST_ERR), 32'd0);
  endtask

  initial begin
    void'($urandom(32'h1cd0));
    repeat (3) @(posedge CLK);
    #1;
    check_reset_values("reset");
    RESETN = 1'b1;
    @(posedge CLK); #1;

    // Nominal burst with immediate ARREADY and back-to-back beats.
    start(29'h0100_0000);
    chk("busy_after_start", 32'(DMA_READY), 32'd0);
    chk("arvalid_after_start", 32'(M_AXI_ARVALID), 32'd1);
    chk("arlen", 32'(M_AXI_ARLEN), 32'd7);
    chk("arsize", 32'(M_AXI_ARSIZE), 32'd2);
    chk("arburst", 32'(M_AXI_ARBURST), 32'd1);
    chk("arcache", 32'(M_AXI_ARCACHE), 32'd3);
    chk("arprot", 32'(M_AXI_ARPROT), 32'd0);
    addr_phase(0, 32'h0400_0000);
    chk("rready_n_plus_2", 32'(M_AXI_RREADY), 32'd1);
    burst_beats(32'hA000_0000, 0, 8, 7, 1'b0);
    chk("ready_after_last", 32'(DMA_READY), 32'd1);
    chk("nominal_last_err", 32'(LAST_ERR), 32'd0);
    end_test(8);

    // AXI stalls: late ARREADY and gaps between R beats.
    start(29'h0ABC_DEF0);
    addr_phase(5, 32'h2AF3_7BC0);
    burst_beats(32'hB000_0000, 0, 8, 7, 1'b1);
    chk("stall_ready", 32'(DMA_READY), 32'd1);
    end_test(8);

    // A second request while busy must be ignored.
    start(29'h0000_0040);
    ar_base = ar_cnt;
    addr_phase(0, 32'h0000_0100);
    burst_beats(32'hC100_0000, 0, 3, 7, 1'b0);
    DMA_RD_ADDR = 29'h0000_1234;
    DMA_START   = 1'b1;
    @(posedge CLK); #1;
    DMA_START   = 1'b0;
    chk("busy_no_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    chk("busy_ready", 32'(DMA_READY), 32'd0);
    burst_beats(32'hC100_0000, 3, 5, 7, 1'b0);
    repeat (3) begin
      @(posedge CLK); #1;
    end
    chk("busy_single_ar", 32'(ar_cnt - ar_base), 32'd1);
    chk("busy_araddr", M_AXI_ARADDR, 32'h0000_0100);
    chk("busy_idle_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    end_test(8);

    // Early RLAST on beat 3: short burst forwarded.
    start(29'h0000_0200);
    addr_phase(0, 32'h0000_0800);
    burst_beats(32'hC000_0000, 0, 4, 3, 1'b0);
    chk("early_last_err", 32'(LAST_ERR), 32'd1);
    chk("early_ready", 32'(DMA_READY), 32'd1);
    end_test(4);
    clear_errors();
    chk("early_clear", 32'(LAST_ERR), 32'd0);

    // Late RLAST on beat 9: beats 8 and 9 drained silently.
    start(29'h0000_0300);
    addr_phase(0, 32'h0000_0C00);
    burst_beats(32'hD000_0000, 0, 8, 99, 1'b0);
    chk("late_last_err", 32'(LAST_ERR), 32'd1);
    chk("late_drain_busy", 32'(DMA_READY), 32'd0);
    chk("late_drain_rready", 32'(M_AXI_RREADY), 32'd1);
    beat(32'hD000_0008, 2'b00, 1'b0, 1'b0, 0, 1'b0);
    beat(32'hD000_0009, 2'b00, 1'b1, 1'b0, 0, 1'b0);
    chk("late_ready", 32'(DMA_READY), 32'd1);
    end_test(8);
    clear_errors();
    chk("late_clear", 32'(LAST_ERR), 32'd0);

    // SLVERR on beat 2 (clear asserted in the same cycle), then reset on beat 5.
    start(29'h0000_0400);
    addr_phase(0, 32'h0000_1000);
    beat(32'hE000_0000, 2'b00, 1'b0, 1'b1, 0, 1'b0);
    beat(32'hE000_0001, 2'b00, 1'b0, 1'b1, 0, 1'b0);
    beat(32'hE000_0002, 2'b10, 1'b0, 1'b1, 0, 1'b1);
    chk("slverr_resp_err", 32'(RESP_ERR), 32'd1);
    beat(32'hE000_0003, 2'b00, 1'b0, 1'b1, 0, 1'b0);
    beat(32'hE000_0004, 2'b00, 1'b0, 1'b1, 0, 1'b0);
    chk("slverr_still_set", 32'(RESP_ERR), 32'd1);
    M_AXI_RVALID = 1'b1;
    M_AXI_RDATA  = 32'hE000_0005;
    @(negedge CLK);
    #1 RESETN = 1'b0;
    #1;
    check_reset_values("midreset");
    M_AXI_RVALID = 1'b0;
    @(posedge CLK); #1;
    RESETN = 1'b1;
    chk("midreset_pulses", 32'(pulse_cnt), 32'd5);
    chk("midreset_queue", 32'(exp_q.size()), 32'd0);
    pulse_cnt = 0;

    // Recovery: a clean burst after the mid-burst reset.
    @(posedge CLK); #1;
    start(29'h0000_0500);
    addr_phase(0, 32'h0000_1400);
    burst_beats(32'hF000_0000, 0, 8, 7, 1'b0);
    chk("recover_ready", 32'(DMA_READY), 32'd1);
    end_test(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
